// File: rtl/stalling_data_memory_if.sv
// Request/response bundle between the M stage and the stalling data memory.
// The pipeline side uses master, the memory side uses slave.
interface stalling_data_memory_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_we;
   logic [3:0]            req_be;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [31:0]           rdata;
   logic                  resp_valid;
   logic                  stall;
   logic                  err;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_wdata,
      input  rdata, resp_valid, stall, err
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_wdata,
      output rdata, resp_valid, stall, err
   );
endinterface

// File: rtl/stalling_data_memory.sv
// Data memory with LATENCY-cycle access, stall handshake and byte-lane stores.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range accesses on err.
module stalling_data_memory #(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int LATENCY     = 2
) (
   input logic clk,
   input logic reset,
   stalling_data_memory_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic             cap_we;
   logic [3:0]       cap_be;
   logic [IDX_W-1:0] cap_idx;
   logic             cap_ok;
   logic [31:0]      cap_wdata;
   logic [31:0]      rdata_q;
   logic             err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             enter_done;
   logic [IDX_W-1:0] req_idx;
   logic             req_ok;
   logic             acc_we;
   logic [3:0]       acc_be;
   logic [IDX_W-1:0] acc_idx;
   logic             acc_ok;
   logic [31:0]      acc_wdata;
   logic             unused_addr;

   assign accept  = (state == IDLE) && bus.req_valid;
   assign req_idx = bus.req_addr[IDX_W+1:2];
   assign unused_addr = ^bus.req_addr;

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
   assign req_ok = {1'b0, bus.req_addr} < LIMIT;
`else
   assign req_ok = 1'b1;
`endif

   // With LATENCY=1 the access edge is the acceptance edge, so use live inputs
   assign enter_done = (accept && LATENCY == 1) ||
                       (state == WAIT && cnt == 4'd1);

   always_comb begin
      acc_we    = cap_we;
      acc_be    = cap_be;
      acc_idx   = cap_idx;
      acc_ok    = cap_ok;
      acc_wdata = cap_wdata;
      if (state == IDLE) begin
         acc_we    = bus.req_we;
         acc_be    = bus.req_be;
         acc_idx   = req_idx;
         acc_ok    = req_ok;
         acc_wdata = bus.req_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_be    <= 4'd0;
         cap_idx   <= '0;
         cap_ok    <= 1'b0;
         cap_wdata <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  cap_we    <= bus.req_we;
                  cap_be    <= bus.req_be;
                  cap_idx   <= req_idx;
                  cap_ok    <= req_ok;
                  cap_wdata <= bus.req_wdata;
                  cnt       <= 4'(LATENCY - 1);
                  state     <= (LATENCY > 1) ? WAIT : DONE;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (enter_done && !acc_we)
            rdata_q <= acc_ok ? mem[acc_idx] : 32'd0;
         if (accept && !req_ok)
            err_q <= 1'b1;
      end
   end

   // Array is not reset; the guard drops an access racing a reset edge
   always_ff @(posedge clk) begin
      if (!reset && enter_done && acc_we && acc_ok) begin
         for (int i = 0; i < 4; i++)
            if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
   end

   assign bus.stall      = (state == IDLE) ? bus.req_valid : (state == WAIT);
   assign bus.resp_valid = (state == DONE);
   assign bus.rdata      = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
   assign bus.err        = err_q;
`else
   assign bus.err        = 1'b0;
`endif
endmodule
